// File: rtl/menu_nav_pkg.sv
// Shared types, key-priority constants and width/step helpers for the menu controller.
// Optional MENU_WRAP_EN: counters wrap at both ends instead of saturating.
package menu_nav_pkg;

  typedef enum logic [1:0] {
    S_MENU    = 2'd0,
    S_PAGE    = 2'd1,
    S_APPLIED = 2'd2
  } state_e;

  // Bit positions in the packed key vector; higher index wins arbitration.
  localparam int unsigned KEY_RIGHT   = 0;
  localparam int unsigned KEY_LEFT    = 1;
  localparam int unsigned KEY_DOWN    = 2;
  localparam int unsigned KEY_UP      = 3;
  localparam int unsigned KEY_CONFIRM = 4;
  localparam int unsigned KEY_QUIT    = 5;
  localparam int unsigned N_KEYS      = 6;

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_QUIT,
    ACT_CONFIRM,
    ACT_UP,
    ACT_DOWN,
    ACT_LEFT,
    ACT_RIGHT
  } action_e;

  function automatic int unsigned sel_w(int unsigned n_items);
    return (n_items <= 2) ? 1 : $clog2(n_items);
  endfunction

  function automatic int unsigned fsel_w(int unsigned n_fields);
    return $clog2(n_fields + 1);
  endfunction

  function automatic action_e arbitrate(logic [N_KEYS-1:0] keys);
    action_e act;
    act = ACT_NONE;
    if      (keys[KEY_QUIT])    act = ACT_QUIT;
    else if (keys[KEY_CONFIRM]) act = ACT_CONFIRM;
    else if (keys[KEY_UP])      act = ACT_UP;
    else if (keys[KEY_DOWN])    act = ACT_DOWN;
    else if (keys[KEY_LEFT])    act = ACT_LEFT;
    else if (keys[KEY_RIGHT])   act = ACT_RIGHT;
    return act;
  endfunction

  // One step of a 0..max counter; inc takes precedence over dec.
  function automatic int unsigned step_val(int unsigned val, int unsigned max,
                                           logic inc, logic dec);
    int unsigned res;
    res = val;
    if (inc) begin
      if (val >= max) begin
`ifdef MENU_WRAP_EN
        res = 0;
`else
        res = max;
`endif
      end else begin
        res = val + 1;
      end
    end else if (dec) begin
      if (val == 0) begin
`ifdef MENU_WRAP_EN
        res = max;
`else
        res = 0;
`endif
      end else begin
        res = val - 1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/menu_step_counter.sv
// Bounded 0..MAX up/down counter with synchronous clear.
// Wraps when MENU_WRAP_EN is defined, saturates otherwise.
module menu_step_counter
  import menu_nav_pkg::*;
#(
  parameter int unsigned MAX = 3,
  parameter int unsigned W   = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = W'(step_val(32'(cnt_q), MAX, inc_i, dec_i));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/menu_nav_ctrl.sv
// Menu/selection controller: key pulses -> item selection, field cursor,
// per-item field banks and apply handshake. Optional MENU_WRAP_EN selects wrapping counters.
module menu_nav_ctrl
  import menu_nav_pkg::*;
#(
  parameter  int unsigned N_ITEMS   = 3,
  parameter  int unsigned N_FIELDS  = 4,
  parameter  int unsigned FIELD_W   = 2,
  parameter  int unsigned FIELD_MAX = 3,
  localparam int unsigned SEL_W     = sel_w(N_ITEMS),
  localparam int unsigned FSEL_W    = fsel_w(N_FIELDS)
) (
  input  logic                        clk_50M,
  input  logic                        rst_n,
  input  logic                        key_left,
  input  logic                        key_right,
  input  logic                        key_up,
  input  logic                        key_down,
  input  logic                        key_confirm,
  input  logic                        key_quit,
  output logic                        level,
  output logic [SEL_W-1:0]            top_sel,
  output logic [SEL_W-1:0]            page_item,
  output logic [FSEL_W-1:0]           field_sel,
  output logic [N_FIELDS*FIELD_W-1:0] field_vals,
  output logic                        apply_valid,
  output logic                        apply_pulse
);

  typedef logic [N_FIELDS-1:0][FIELD_W-1:0] bank_t;

  logic [N_KEYS-1:0] keys;
  action_e           act;
  state_e            state_q, state_d;
  logic [SEL_W-1:0]  page_item_q, page_item_d;
  logic              apply_pulse_q, apply_pulse_d;
  bank_t             bank_q [N_ITEMS];
  bank_t             bank_d [N_ITEMS];

  logic top_en, top_inc, top_dec;
  logic fld_en, fld_clr, fld_inc, fld_dec;
  logic edit_en, edit_inc, edit_dec;
  logic on_apply;

  always_comb begin
    keys              = '0;
    keys[KEY_QUIT]    = key_quit;
    keys[KEY_CONFIRM] = key_confirm;
    keys[KEY_UP]      = key_up;
    keys[KEY_DOWN]    = key_down;
    keys[KEY_LEFT]    = key_left;
    keys[KEY_RIGHT]   = key_right;
  end

  assign act      = arbitrate(keys);
  assign on_apply = (field_sel == FSEL_W'(N_FIELDS));

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    page_item_d   = page_item_q;
    apply_pulse_d = 1'b0;
    top_en        = 1'b0;
    top_inc       = 1'b0;
    top_dec       = 1'b0;
    fld_en        = 1'b0;
    fld_clr       = 1'b0;
    fld_inc       = 1'b0;
    fld_dec       = 1'b0;
    edit_en       = 1'b0;
    edit_inc      = 1'b0;
    edit_dec      = 1'b0;

    unique case (state_q)
      S_MENU: begin
        case (act)
          ACT_LEFT:  begin top_en = 1'b1; top_dec = 1'b1; end
          ACT_RIGHT: begin top_en = 1'b1; top_inc = 1'b1; end
          ACT_CONFIRM: begin
            page_item_d = top_sel;
            fld_clr     = 1'b1;
            state_d     = S_PAGE;
          end
          default: ;
        endcase
      end
      S_PAGE, S_APPLIED: begin
        case (act)
          ACT_UP:   begin fld_en = 1'b1; fld_dec = 1'b1; state_d = S_PAGE; end
          ACT_DOWN: begin fld_en = 1'b1; fld_inc = 1'b1; state_d = S_PAGE; end
          ACT_LEFT, ACT_RIGHT: begin
            edit_en  = !on_apply;
            edit_inc = (act == ACT_RIGHT);
            edit_dec = (act == ACT_LEFT);
            state_d  = S_PAGE;
          end
          ACT_CONFIRM: begin
            // Re-confirming an already applied page must not re-strobe.
            if (state_q == S_PAGE && on_apply) begin
              apply_pulse_d = 1'b1;
              state_d       = S_APPLIED;
            end
          end
          ACT_QUIT: state_d = S_MENU;
          default: ;
        endcase
      end
      default: state_d = S_MENU;
    endcase
  end

  always_comb begin
    for (int i = 0; i < N_ITEMS; i++) begin
      bank_d[i] = bank_q[i];
      for (int f = 0; f < N_FIELDS; f++) begin
        if (edit_en && page_item_q == SEL_W'(i) && field_sel == FSEL_W'(f)) begin
          bank_d[i][f] = FIELD_W'(step_val(32'(bank_q[i][f]), FIELD_MAX,
                                           edit_inc, edit_dec));
        end
      end
    end
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_MENU;
      page_item_q   <= '0;
      apply_pulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      page_item_q   <= page_item_d;
      apply_pulse_q <= apply_pulse_d;
    end
  end

  // NOTE: the value banks are deliberately reset; field_vals must read zero
  // straight out of reset, so this storage cannot map to an unreset RAM.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ITEMS; i++) begin
        bank_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_ITEMS; i++) begin
        bank_q[i] <= bank_d[i];
      end
    end
  end

  menu_step_counter #(
    .MAX (N_ITEMS - 1),
    .W   (SEL_W)
  ) u_top_cnt (
    .clk   (clk_50M),
    .rst_n (rst_n),
    .en_i  (top_en),
    .clr_i (1'b0),
    .inc_i (top_inc),
    .dec_i (top_dec),
    .cnt_o (top_sel)
  );

  menu_step_counter #(
    .MAX (N_FIELDS),
    .W   (FSEL_W)
  ) u_field_cnt (
    .clk   (clk_50M),
    .rst_n (rst_n),
    .en_i  (fld_en),
    .clr_i (fld_clr),
    .inc_i (fld_inc),
    .dec_i (fld_dec),
    .cnt_o (field_sel)
  );

  // Banks stay visible through page_item even while back in the top menu.
  always_comb begin
    field_vals = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (page_item_q == SEL_W'(i)) field_vals = bank_q[i];
    end
  end

  assign level       = (state_q != S_MENU);
  assign apply_valid = (state_q == S_APPLIED);
  assign apply_pulse = apply_pulse_q;
  assign page_item   = page_item_q;

endmodule

// File: doc/menu_nav_ctrl.md
Name: menu_nav_ctrl

Overview:
- Parametrised successor to the top-level menu/selection controller.
- Turns single-cycle debounced key pulses into:
  - a top-level item selection;
  - a per-item field cursor;
  - per-item field value banks;
  - an apply handshake to the generator/scope back-ends.
- Sits between the button_debounce instances and the sig_gen / hdmi_dis_top consumers.
- Generalises item count, field count and field width, and retains field values per item across page exits.

Parameters:
- N_ITEMS, 3: number of top-level menu items (min 2).
- N_FIELDS, 4: editable fields per item page (min 1); the cursor also has an extra "apply" row at index N_FIELDS.
- FIELD_W, 2: width of each field value.
- FIELD_MAX, 3: maximum field value (≤ 2^FIELD_W − 1); the minimum is 0.

Ports:
- clk_50M  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- key_left  in  1  one-cycle release pulse.
- key_right  in  1  one-cycle release pulse.
- key_up  in  1  one-cycle release pulse.
- key_down  in  1  one-cycle release pulse.
- key_confirm  in  1  one-cycle release pulse.
- key_quit  in  1  one-cycle release pulse.
- level  out  1  0 = top menu, 1 = inside an item page.
- top_sel  out  SEL_W  highlighted top-level item; SEL_W = max(1, clog2(N_ITEMS)).
- page_item  out  SEL_W  item whose page is open (valid when level=1).
- field_sel  out  FSEL_W  cursor row 0..N_FIELDS; FSEL_W = clog2(N_FIELDS+1).
- field_vals  out  N_FIELDS*FIELD_W  packed field values of the bank for page_item; field 0 occupies the LSBs.
- apply_valid  out  1  level: the current page's values are applied.
- apply_pulse  out  1  one-cycle strobe when an apply is accepted.

Behaviour:
- Clock and reset:
  - Single clock domain, clk_50M; reset is asynchronous, active-low (rst_n).
  - All state is registered; no combinational state feedback.
- Reset values:
  - State = S_MENU.
  - level = 0, top_sel = 0, page_item = 0, field_sel = 0.
  - All banks = 0, apply_valid = 0, apply_pulse = 0.
- Latency: every output reflects a key pulse on the clock edge after the pulse (1 cycle).
- Key arbitration: at most one action per cycle, priority quit > confirm > up > down > left > right. Lower-priority pulses in the same cycle are dropped.
- Navigation rule for each counter (top_sel, field_sel, field value):
  - Increment at MAX wraps to 0; decrement at 0 wraps to MAX (see optional feature).
  - MAX is N_ITEMS−1 for top_sel, N_FIELDS for field_sel, FIELD_MAX for field values.
- S_MENU (level = 0):
  - left/right: decrement/increment top_sel.
  - confirm: page_item ← top_sel, field_sel ← 0, go to S_PAGE.
  - quit, up, down: ignored.
- S_PAGE (level = 1):
  - up/down: decrement/increment field_sel.
  - left/right with field_sel < N_FIELDS: decrement/increment bank[page_item][field_sel]. Ignored on the apply row.
  - confirm with field_sel == N_FIELDS: apply_pulse = 1 for one cycle, apply_valid ← 1, go to S_APPLIED. Confirm on other rows is ignored.
  - quit: go to S_MENU. top_sel is kept (not cleared); the bank is retained.
- S_APPLIED (level = 1):
  - left/right: perform the edit, clear apply_valid, return to S_PAGE (dirty edit).
  - up/down: move the cursor, clear apply_valid, return to S_PAGE.
  - confirm: ignored; no second apply_pulse.
  - quit: apply_valid ← 0, go to S_MENU.
- Banks are cleared only by rst_n.
- field_vals always muxes the bank selected by page_item, including while in S_MENU.
- Reset asserted mid-operation: immediate return to reset values regardless of state; the pulse in flight is lost.

Optional Feature:
- Macro: MENU_WRAP_EN.
- Defined: all counters wrap as above.
- Undefined: all counters saturate at 0 and MAX; a pulse at a boundary is a no-op (no state or flag change, except that apply_valid is still cleared in S_APPLIED).

Decomposition:
- Package menu_nav_pkg holds:
  - state enum S_MENU = 0, S_PAGE = 1, S_APPLIED = 2 (2 bits);
  - key-priority index constants;
  - the SEL_W / FSEL_W computation functions.
- Sub-module menu_step_counter: parametrised MAX and width; inputs inc, dec, en; wrap/saturate selected by MENU_WRAP_EN.
  - Instantiated for top_sel and field_sel.
  - Field edits use its step function on the addressed bank entry.

Test Plan:
- Reset, then 3× key_right in S_MENU → top_sel sequence 1, 2, 0 (wrap). With MENU_WRAP_EN undefined → 1, 2, 2.
- key_confirm at top_sel=1; 2× key_right; key_down; key_left → level=1, page_item=1, field_vals[1:0]=2, field_vals[3:2]=3 (wrap from 0).
- Cursor to row 4, key_confirm → apply_pulse high for exactly 1 cycle, apply_valid=1. Second key_confirm → no pulse. key_right → apply_valid=0, state S_PAGE.
- key_quit; key_right to item 2; confirm → field_vals=0. Quit, go back to item 1, confirm → field_vals[3:0]=4'b1110 (retained).
- Same-cycle key_quit+key_confirm in S_PAGE → S_MENU, no apply_pulse. Same-cycle key_up+key_left → only field_sel changes.
- Assert rst_n low asynchronously while in S_APPLIED → all outputs 0 before the next clock edge; banks cleared.
